// File: rtl/pipe_ctrl.sv
// Pipeline control for an N-stage in-order pipe: per-stage keep (hold) and
// dirty (bubble) from stall/flush/extend requests, plus a front-end stall counter.
module pipe_ctrl #(
  parameter int STAGES     = 5,
  parameter int EXT_CYCLES = 2,
  parameter int EXT_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall,
  input  logic [STAGES-1:0] flush,
  input  logic [STAGES-1:0] extend,
  output logic [STAGES-1:0] keep,
  output logic [STAGES-1:0] dirty,
  output logic              empty,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [EXT_W-1:0] EXT_LOAD = EXT_W'(EXT_CYCLES - 1);

  logic [STAGES-1:0] dirty_q, dirty_d;
  logic [EXT_W-1:0]  cnt_q [STAGES];
  logic [EXT_W-1:0]  cnt_d [STAGES];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [STAGES-1:0] ext_busy;
  logic [STAGES-1:0] local_hold;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] hold_up;
  logic [STAGES-1:0] dirty_up;

  // Hold propagates from write-back toward fetch: any held stage backs up all above it.
  always_comb begin
    ext_busy = '0;
    hold     = '0;
    for (int i = 0; i < STAGES; i++) begin
      ext_busy[i] = (cnt_q[i] != '0) | (extend[i] & ~dirty_q[i]);
    end
    local_hold = stall | ext_busy;
    hold[0]    = local_hold[0];
    for (int i = 1; i < STAGES; i++) begin
      hold[i] = local_hold[i] | hold[i-1];
    end
  end

  // Upstream view of each stage; zero-filled above fetch so fetch always refills valid.
  assign hold_up  = hold >> 1;
  assign dirty_up = dirty_q >> 1;

  always_comb begin
    dirty_d = dirty_q;
    for (int i = 0; i < STAGES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush[i]) begin
        dirty_d[i] = 1'b1;
        cnt_d[i]   = '0;
      end else begin
        if (!hold[i]) begin
          dirty_d[i] = hold_up[i] | dirty_up[i];
        end
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - EXT_W'(1);
        end else if (extend[i] & ~dirty_q[i]) begin
          cnt_d[i] = EXT_LOAD;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold[STAGES-1] && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_q     <= '1;
      stall_cnt_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      dirty_q     <= dirty_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < STAGES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign keep      = rst ? '0 : hold;
  assign dirty     = dirty_q;
  assign empty     = &dirty_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (5 stages, 3-cycle extend, 4-bit stall counter)
// against a stage-occupancy reference model.
module tb_pipe_ctrl;

  localparam int N   = 5;
  localparam int EXT = 3;
  localparam int CW  = 4;
  localparam int CMAX = 15;

  logic          clk;
  logic          rst;
  logic [N-1:0]  stall, flush, extend;
  logic [N-1:0]  keep, dirty;
  logic          empty;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: which stages hold real work, remaining extend cycles, stall count.
  bit       mval [N];
  int       mrem [N];
  int       mcnt;
  logic [N-1:0] mkeep;

  pipe_ctrl #(.STAGES(N), .EXT_CYCLES(EXT), .EXT_W(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .extend(extend),
    .keep(keep), .dirty(dirty), .empty(empty), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [N-1:0] mdirty();
    logic [N-1:0] d;
    for (int i = 0; i < N; i++) d[i] = !mval[i];
    return d;
  endfunction

  function automatic logic [N-1:0] rbits(input int one_in);
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = ($urandom_range(0, one_in - 1) == 0);
    return b;
  endfunction

  // Apply inputs for the coming cycle, predict keep, and stop at mid-cycle.
  task automatic set_in(input logic [N-1:0] s, input logic [N-1:0] f, input logic [N-1:0] e);
    bit any;
    stall = s; flush = f; extend = e;
    any = 0;
    for (int i = 0; i < N; i++) begin
      if (s[i] || mrem[i] > 0 || (e[i] && mval[i])) any = 1;
      mkeep[i] = any && !rst;
    end
    @(negedge clk);
  endtask

  // Advance one clock edge in both DUT and model, then settle.
  task automatic clk_edge();
    bit nv [N];
    int nr [N];
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin mval[i] = 0; mrem[i] = 0; end
      mcnt = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (flush[i]) begin
          nv[i] = 0; nr[i] = 0;
        end else begin
          if (mkeep[i])        nv[i] = mval[i];
          else if (i == N - 1) nv[i] = 1;
          else                 nv[i] = mkeep[i+1] ? 1'b0 : mval[i+1];
          if (mrem[i] > 0)                 nr[i] = mrem[i] - 1;
          else if (extend[i] && mval[i])   nr[i] = EXT - 1;
          else                             nr[i] = 0;
        end
      end
      for (int i = 0; i < N; i++) begin mval[i] = nv[i]; mrem[i] = nr[i]; end
      if (mkeep[N-1] && mcnt < CMAX) mcnt = mcnt + 1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      set_in('0, '0, '0);
      clk_edge();
    end
  endtask

  task automatic test_reset();
    logic [N-1:0] exp_d;
    rst = 1'b1;
    set_in('1, '1, '1);
    checks++; if (keep !== 5'b00000) begin errors++; $display("FAIL reset_keep got %b exp %b", keep, 5'b00000); end
    clk_edge();
    set_in('0, '0, '0);
    clk_edge();
    checks++; if (dirty !== 5'b11111) begin errors++; $display("FAIL reset_dirty got %b exp %b", dirty, 5'b11111); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      set_in('0, '0, '0);
      checks++; if (keep !== 5'b00000) begin errors++; $display("FAIL fill_keep got %b exp %b", keep, 5'b00000); end
      clk_edge();
      exp_d = 5'b11111 >> (k + 1);
      checks++; if (dirty !== exp_d) begin errors++; $display("FAIL fill_dirty step %0d got %b exp %b", k, dirty, exp_d); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty step %0d got %b exp 0", k, empty); end
    end
  endtask

  task automatic test_stall();
    set_in(5'b01000, '0, '0);
    checks++; if (keep !== 5'b11000) begin errors++; $display("FAIL stall_keep got %b exp %b", keep, 5'b11000); end
    clk_edge();
    checks++; if (dirty !== 5'b00100) begin errors++; $display("FAIL stall_dirty got %b exp %b", dirty, 5'b00100); end
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL stall_cnt got %0d exp 1", stall_cnt); end
    idle(5);
    checks++; if (dirty !== 5'b00000) begin errors++; $display("FAIL stall_drain got %b exp %b", dirty, 5'b00000); end
  endtask

  task automatic test_flush_stall();
    set_in(5'b01000, 5'b01000, '0);
    checks++; if (keep !== 5'b11000) begin errors++; $display("FAIL fs_keep got %b exp %b", keep, 5'b11000); end
    clk_edge();
    checks++; if (dirty[3] !== 1'b1 || dirty[4] !== 1'b0) begin errors++; $display("FAIL fs_dirty got %b exp D bubble F valid", dirty); end
    checks++; if (dirty !== mdirty()) begin errors++; $display("FAIL fs_dirty_model got %b exp %b", dirty, mdirty()); end
    set_in('0, '0, '0);
    checks++; if (keep !== 5'b00000) begin errors++; $display("FAIL fs_release_keep got %b exp %b", keep, 5'b00000); end
    clk_edge();
    checks++; if (dirty[2] !== 1'b1 || dirty[3] !== 1'b0) begin errors++; $display("FAIL fs_move got %b exp E bubble D refilled", dirty); end
    checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL fs_cnt got %0d exp 2", stall_cnt); end
    idle(5);
  endtask

  task automatic test_extend();
    logic [N-1:0] e;
    for (int k = 0; k < 4; k++) begin
      e = (k < 2) ? 5'b00010 : 5'b00000;
      set_in('0, '0, e);
      if (k < 3) begin
        checks++; if (keep !== 5'b11110) begin errors++; $display("FAIL ext_keep cycle %0d got %b exp %b", k, keep, 5'b11110); end
      end else begin
        checks++; if (keep !== 5'b00000) begin errors++; $display("FAIL ext_release got %b exp %b", keep, 5'b00000); end
      end
      clk_edge();
      if (k < 3) begin
        checks++; if (dirty !== 5'b00001) begin errors++; $display("FAIL ext_dirty cycle %0d got %b exp %b", k, dirty, 5'b00001); end
      end else begin
        checks++; if (dirty !== 5'b00000) begin errors++; $display("FAIL ext_dirty_clear got %b exp %b", dirty, 5'b00000); end
      end
    end
    checks++; if (stall_cnt !== 4'd5) begin errors++; $display("FAIL ext_cnt got %0d exp 5", stall_cnt); end
  endtask

  task automatic test_extend_dirty();
    set_in('0, 5'b00100, '0);
    clk_edge();
    checks++; if (dirty !== 5'b00100) begin errors++; $display("FAIL xd_flush got %b exp %b", dirty, 5'b00100); end
    set_in('0, '0, 5'b00100);
    checks++; if (keep !== 5'b00000) begin errors++; $display("FAIL xd_keep got %b exp %b", keep, 5'b00000); end
    clk_edge();
    set_in('0, '0, '0);
    checks++; if (keep !== 5'b00000) begin errors++; $display("FAIL xd_counter got keep %b exp %b", keep, 5'b00000); end
    clk_edge();
    idle(4);
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 20; k++) begin
      set_in(5'b10000, '0, '0);
      checks++; if (keep !== 5'b10000) begin errors++; $display("FAIL sat_keep cycle %0d got %b exp %b", k, keep, 5'b10000); end
      clk_edge();
      checks++; if (stall_cnt !== mcnt[CW-1:0]) begin errors++; $display("FAIL sat_cnt_model cycle %0d got %0d exp %0d", k, stall_cnt, mcnt); end
    end
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d exp 15", stall_cnt); end
    rst = 1'b1;
    set_in(5'b10110, 5'b00101, 5'b01010);
    checks++; if (keep !== 5'b00000) begin errors++; $display("FAIL rst_mid_keep got %b exp %b", keep, 5'b00000); end
    clk_edge();
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d exp 0", stall_cnt); end
    checks++; if (dirty !== 5'b11111) begin errors++; $display("FAIL rst_mid_dirty got %b exp %b", dirty, 5'b11111); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_in(rbits(8), rbits(16), rbits(6));
      checks++; if (keep !== mkeep) begin errors++; $display("FAIL rnd_keep cycle %0d got %b exp %b", k, keep, mkeep); end
      clk_edge();
      checks++; if (dirty !== mdirty()) begin errors++; $display("FAIL rnd_dirty cycle %0d got %b exp %b", k, dirty, mdirty()); end
      checks++; if (empty !== (&mdirty())) begin errors++; $display("FAIL rnd_empty cycle %0d got %b exp %b", k, empty, &mdirty()); end
      checks++; if (stall_cnt !== mcnt[CW-1:0]) begin errors++; $display("FAIL rnd_cnt cycle %0d got %0d exp %0d", k, stall_cnt, mcnt); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall = '0; flush = '0; extend = '0;
    for (int i = 0; i < N; i++) begin mval[i] = 0; mrem[i] = 0; end
    mcnt = 0;
    mkeep = '0;
    test_reset();
    test_stall();
    test_flush_stall();
    test_extend();
    test_extend_dirty();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
